// File: rtl/handshake_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : handshake_tx_queue
// Purpose  : Buffers a ready/valid word stream and issues words to the
//            handshake synchronizer as one-cycle pulses when it is not busy.
//            Define HANDSHAKE_TX_QUEUE_STATS_EN to add issued_count_o.
// Revision : 1.0  initial release
// ============================================================================
module handshake_tx_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic                    busy_i,
    output logic                    valid_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [$clog2(DEPTH):0]  level_o
`ifdef HANDSHAKE_TX_QUEUE_STATS_EN
    ,
    output logic [15:0]             issued_count_o
`endif
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_pw = c_aw + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_HOLD = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_data;
    logic [c_pw-1:0]        r_wr_ptr;
    logic [c_pw-1:0]        r_rd_ptr;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    logic                   w_empty;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                     (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
    // Full blocks the write even when a pop frees a slot in the same cycle.
    assign w_push  = in_valid_i && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !busy_i;

    assign in_ready_o = !w_full;
    assign level_o    = r_wr_ptr - r_rd_ptr;
    assign valid_o    = r_valid;
    assign data_o     = r_data;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_pw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_pw'(1);
            end
        end
    end

    // HOLD ignores busy_i for one cycle to cover the synchronizer's busy latency.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_SEND;
                        r_valid <= 1'b1;
                        r_data  <= r_mem[r_rd_ptr[c_aw-1:0]];
                    end
                end
                S_SEND: begin
                    r_state <= S_HOLD;
                    r_valid <= 1'b0;
                end
                S_HOLD: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!busy_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef HANDSHAKE_TX_QUEUE_STATS_EN
    logic [15:0] r_issued_count;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_issued_count <= 16'd0;
        end else if ((r_state == S_SEND) && (r_issued_count != 16'hFFFF)) begin
            r_issued_count <= r_issued_count + 16'd1;
        end
    end

    assign issued_count_o = r_issued_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_handshake_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_tx_queue
// Purpose  : Directed self-checking bench for handshake_tx_queue (DEPTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_handshake_tx_queue;

    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  in_data = '0;
    logic           busy = 1'b0;
    logic           valid;
    logic [DW-1:0]  data;
    logic [2:0]     level;
`ifdef HANDSHAKE_TX_QUEUE_STATS_EN
    logic [15:0]    issued_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] expq[$];
    logic [31:0] exp_word;
    int          sent;
    int          got;
    int          lvl;
    int          last_pulse;
    bit          do_push;
    bit          accept;

    handshake_tx_queue #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .busy_i     (busy),
        .valid_o    (valid),
        .data_o     (data),
        .level_o    (level)
`ifdef HANDSHAKE_TX_QUEUE_STATS_EN
        ,
        .issued_count_o (issued_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // busy_i held high through HOLD, WAIT and 10 more cycles, then released.
    task automatic gap_then_send(input logic [31:0] prev, input logic [31:0] nxt,
                                 input logic [2:0] nlevel);
        busy = 1'b1;
        step();
        chk("hold_valid", {31'd0, valid}, 32'd0);
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("busy_valid", {31'd0, valid}, 32'd0);
            chk("busy_data_stable", data, prev);
        end
        busy = 1'b0;
        step();
        chk("release_valid", {31'd0, valid}, 32'd0);
        step();
        chk("next_valid", {31'd0, valid}, 32'd1);
        chk("next_data", data, nxt);
        chk("next_level", {29'd0, level}, {29'd0, nlevel});
    endtask

`ifdef HANDSHAKE_TX_QUEUE_STATS_EN
    task automatic push_one(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
        repeat (5) step();
    endtask
`endif

    initial begin
        // Reset state
        #2;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        step();
        reset_n = 1'b1;
        step();

        // Single word
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        chk("single_level_q", {29'd0, level}, 32'd1);
        chk("single_nopulse", {31'd0, valid}, 32'd0);
        step();
        chk("single_valid", {31'd0, valid}, 32'd1);
        chk("single_data", data, 32'hDEADBEEF);
        chk("single_level", {29'd0, level}, 32'd0);
        step();
        chk("single_pulse_end", {31'd0, valid}, 32'd0);
        chk("single_data_hold", data, 32'hDEADBEEF);
        step();
        step();

        // Burst to full with busy high
        busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(i + 1);
            chk("burst_ready", {31'd0, in_ready}, (i < 4) ? 32'd1 : 32'd0);
            step();
            chk("burst_novalid", {31'd0, valid}, 32'd0);
        end
        chk("burst_level", {29'd0, level}, 32'd4);
        chk("burst_full", {31'd0, in_ready}, 32'd0);

        // Pop while full with producer still pushing: push is refused
        busy = 1'b0;
        step();
        in_valid = 1'b0;
        chk("fullpop_valid", {31'd0, valid}, 32'd1);
        chk("fullpop_data", data, 32'd1);
        chk("fullpop_level", {29'd0, level}, 32'd3);
        chk("fullpop_ready", {31'd0, in_ready}, 32'd1);

        // Busy gating, ordered exit
        gap_then_send(32'd1, 32'd2, 3'd2);
        gap_then_send(32'd2, 32'd3, 3'd1);
        gap_then_send(32'd3, 32'd4, 3'd0);
        busy = 1'b0;
        step();
        step();
        step();

        // Wrap-around stream with random busy
        sent = 0;
        got = 0;
        lvl = 0;
        last_pulse = -10;
        for (int cyc = 0; cyc < 600 && got < 11; cyc++) begin
            do_push  = (sent < 11) && ($urandom_range(0, 3) != 0);
            in_valid = do_push;
            in_data  = 32'hA000_0000 + 32'(sent);
            busy     = ($urandom_range(0, 2) == 0);
            accept   = do_push && (lvl < 4);
            step();
            if (valid) begin
                if (expq.size() == 0) begin
                    chk("wrap_spurious", 32'd1, 32'd0);
                end else begin
                    exp_word = expq.pop_front();
                    chk("wrap_data", data, exp_word);
                    lvl--;
                end
                chk("wrap_spacing", {31'd0, (cyc - last_pulse) >= 4}, 32'd1);
                last_pulse = cyc;
                got++;
            end
            if (accept) begin
                expq.push_back(32'hA000_0000 + 32'(sent));
                sent++;
                lvl++;
            end
            chk("wrap_level", {29'd0, level}, 32'(lvl));
        end
        in_valid = 1'b0;
        busy = 1'b0;
        chk("wrap_count", 32'(got), 32'd11);
        repeat (4) step();

        // Reset mid-WAIT with 3 queued
        busy = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hC0 + 32'(i);
            if (i >= 2) busy = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_level", {29'd0, level}, 32'd3);
        chk("pre_rst_data", data, 32'hC0);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_data", data, 32'd0);
        chk("arst_level", {29'd0, level}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        busy = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_nopulse", {31'd0, valid}, 32'd0);
        end
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

`ifdef HANDSHAKE_TX_QUEUE_STATS_EN
        chk("stats_reset", {16'd0, issued_count}, 32'd0);
        for (int i = 0; i < 7; i++) push_one(32'h100 + 32'(i));
        chk("stats_seven", {16'd0, issued_count}, 32'd7);
        force dut.r_issued_count = 16'hFFFE;
        #1;
        release dut.r_issued_count;
        for (int i = 0; i < 3; i++) push_one(32'h200 + 32'(i));
        chk("stats_sat", {16'd0, issued_count}, 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
